// File: rtl/ieee754_pkg.sv
// Shared IEEE-754 single-precision field widths, FSM states, operand classes
// and result flags for the float-to-fixed converter.
package ieee754_pkg;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam int MANT_W = FRAC_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_SHIFT,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_NAN,
        CLS_SAT,
        CLS_NEG,
        CLS_ZERO,
        CLS_INEXACT
    } cls_t;

    typedef struct packed {
        logic sat;
        logic nan;
        logic neg;
        logic inexact;
    } flags_t;
endpackage

// File: rtl/ieee754_classify.sv
// Combinational decode of a single-precision operand into a special-case class
// and the right-shift count that aligns {1,f} to an integer.
module ieee754_classify
    import ieee754_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic              sign,
    input  logic [EXP_W-1:0]  exponent,
    input  logic [FRAC_W-1:0] fraction,
    output cls_t              cls,
    output logic [4:0]        shift_cnt
);
    // Largest exponent whose integer part still fits in OUT_W bits.
    localparam logic [EXP_W-1:0] SAT_EXP = EXP_W'(BIAS - 1 + OUT_W);
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] ONE_EXP = EXP_W'(BIAS);
    localparam logic [EXP_W-1:0] INT_EXP = EXP_W'(BIAS + FRAC_W);

    logic frac_nz;
    logic exp_zero;

    assign frac_nz  = |fraction;
    assign exp_zero = ~|exponent;

    always_comb begin
        cls = CLS_NORMAL;
        if (exponent == EXP_MAX)
            cls = frac_nz ? CLS_NAN : (sign ? CLS_NEG : CLS_SAT);
        else if (exp_zero && !frac_nz)
            cls = CLS_ZERO;
        else if (sign)
            cls = CLS_NEG;
        else if (exponent < ONE_EXP)
            cls = CLS_INEXACT;
        else if (exponent > SAT_EXP)
            cls = CLS_SAT;
    end

    assign shift_cnt = 5'(INT_EXP - exponent);
endmodule

// File: rtl/float_to_fixed_conv.sv
// Converts an IEEE-754 single to an OUT_W-bit unsigned integer (truncating),
// using a one-bit-per-cycle right shifter with a sticky bit for inexactness.
module float_to_fixed_conv
    import ieee754_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_nan,
    output logic             out_neg,
    output logic             out_inexact
);
    state_t             state, state_nxt;
    logic [31:0]        op_q;
    logic [MANT_W-1:0]  mant_q;
    logic [MANT_W-1:0]  mant_full;
    logic [MANT_W-1:0]  mant_shr;
    logic [4:0]         cnt_q;
    logic               sticky_q;
    logic               sticky_nxt;
    logic [OUT_W-1:0]   data_q;
    flags_t             flags_q;
    cls_t               cls;
    logic [4:0]         shift_cnt;

    ieee754_classify #(.OUT_W(OUT_W)) u_classify (
        .sign      (op_q[31]),
        .exponent  (op_q[30:23]),
        .fraction  (op_q[22:0]),
        .cls       (cls),
        .shift_cnt (shift_cnt)
    );

    assign mant_full  = {1'b1, op_q[FRAC_W-1:0]};
    assign mant_shr   = mant_q >> 1;
    assign sticky_nxt = sticky_q | mant_q[0];

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (in_valid) state_nxt = ST_CLASSIFY;
            ST_CLASSIFY: state_nxt = (cls != CLS_NORMAL || shift_cnt == 5'd0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT:    if (cnt_q == 5'd1) state_nxt = ST_DONE;
            ST_DONE:     if (out_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q     <= '0;
            mant_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            data_q   <= '0;
            flags_q  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: if (in_valid) op_q <= in_data;
                ST_CLASSIFY: begin
                    data_q  <= '0;
                    flags_q <= '0;
                    unique case (cls)
                        CLS_NAN:     flags_q.nan     <= 1'b1;
                        CLS_NEG:     flags_q.neg     <= 1'b1;
                        CLS_INEXACT: flags_q.inexact <= 1'b1;
                        CLS_SAT: begin
                            flags_q.sat <= 1'b1;
                            data_q      <= '1;
                        end
                        CLS_NORMAL: begin
                            mant_q   <= mant_full;
                            cnt_q    <= shift_cnt;
                            sticky_q <= 1'b0;
                            // Exponent already at the integer position: no shifting needed.
                            if (shift_cnt == 5'd0) data_q <= mant_full[OUT_W-1:0];
                        end
                        default: ;
                    endcase
                end
                ST_SHIFT: begin
                    mant_q   <= mant_shr;
                    sticky_q <= sticky_nxt;
                    cnt_q    <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        data_q          <= mant_shr[OUT_W-1:0];
                        flags_q.inexact <= sticky_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == ST_IDLE);
    assign out_valid   = (state == ST_DONE);
    assign out_data    = data_q;
    assign out_sat     = flags_q.sat;
    assign out_nan     = flags_q.nan;
    assign out_neg     = flags_q.neg;
    assign out_inexact = flags_q.inexact;
endmodule

// File: tb/tb_float_to_fixed_conv.sv
// Scoreboard bench: driver pushes reference-model results on accept, a monitor
// pops and compares each presented result, its latency and its stability.
module tb_float_to_fixed_conv;
    localparam int OUT_W = 16;

    typedef struct {
        logic [31:0]      op;
        logic [OUT_W-1:0] data;
        logic [3:0]       flags;   // {sat, nan, neg, inexact}
        int               lat;
        int               acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             out_sat, out_nan, out_neg, out_inexact;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   stall_req = 1'b0;
    exp_t sb[$];

    float_to_fixed_conv #(.OUT_W(OUT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .out_nan     (out_nan),
        .out_neg     (out_neg),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Value-level model: integer part of (-1)^s * 1.f * 2^(e-127), clamped to OUT_W bits.
    function automatic exp_t ref_model(input logic [31:0] v);
        exp_t   r;
        int     e;
        longint m, ip, lim;
        e   = int'(v[30:23]);
        m   = longint'({1'b1, v[22:0]});
        lim = longint'(1) << OUT_W;
        r.op = v; r.data = '0; r.flags = 4'b0000; r.lat = 1; r.acc = 0;
        if (e == 255 && v[22:0] != 0) r.flags = 4'b0100;
        else if (v[30:0] == 0) begin end
        else if (v[31]) r.flags = 4'b0010;
        else if (e == 255) begin r.flags = 4'b1000; r.data = '1; end
        else if (e < 127) r.flags = 4'b0001;
        else begin
            if (e >= 150) ip = (e - 150 >= 32) ? lim : (m << (e - 150));
            else          ip = m >> (150 - e);
            if (ip >= lim) begin
                r.flags = 4'b1000; r.data = '1;
            end else begin
                r.data = OUT_W'(ip);
                if (e < 150) begin
                    r.flags[0] = ((m & ((longint'(1) << (150 - e)) - 1)) != 0);
                    r.lat = 150 - e + 1;
                end
            end
        end
        return r;
    endfunction

    task automatic send(input logic [31:0] v);
        int   t = 0;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for op 0x%08h", v);
            in_valid = 1'b0;
            return;
        end
        e = ref_model(v);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom();
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_out_data"},  32'(out_data),  32'd0);
        chk({nm, "_flags"}, 32'({out_sat, out_nan, out_neg, out_inexact}), 32'd0);
        chk({nm, "_in_ready"},  32'(in_ready),  32'd1);
    endtask

    // Monitor: compare on first presentation, then require stability until handshake.
    initial begin : monitor
        bit   seen = 1'b0;
        bit   hs_pend = 1'b0;
        int   hold = 0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                seen = 1'b0; hs_pend = 1'b0; hold = 0;
            end else begin
                if (hs_pend) begin
                    chk("ready_after_release", 32'(in_ready), 32'd1);
                    chk("valid_dropped", 32'(out_valid), 32'd0);
                end
                hs_pend = 1'b0;
                if (out_valid) begin
                    chk("in_ready_while_busy", 32'(in_ready), 32'd0);
                    if (!seen) begin
                        seen = 1'b1;
                        if (sb.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_result: data 0x%0h with empty scoreboard", out_data);
                        end else begin
                            cur = sb.pop_front();
                            chk($sformatf("data[%08h]", cur.op), 32'(out_data), 32'(cur.data));
                            chk($sformatf("flags[%08h]", cur.op),
                                32'({out_sat, out_nan, out_neg, out_inexact}), 32'(cur.flags));
                            chk($sformatf("latency[%08h]", cur.op), 32'(cyc - cur.acc), 32'(cur.lat));
                            if (stall_req) begin hold = 10; stall_req = 1'b0; end
                        end
                    end else begin
                        chk("hold_data", 32'(out_data), 32'(cur.data));
                        chk("hold_flags", 32'({out_sat, out_nan, out_neg, out_inexact}), 32'(cur.flags));
                    end
                    if (hold > 0) begin out_ready = 1'b0; hold--; end
                    else out_ready = ($urandom_range(0, 3) != 0);
                    hs_pend = out_ready;
                end else begin
                    seen = 1'b0;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    logic [31:0] directed [12] = '{
        32'h3F800000, 32'h477FFF00, 32'h47800000, 32'h40200000,
        32'h3F000000, 32'h7FC00000, 32'hBF800000, 32'hFF800000,
        32'h80000000, 32'h00000000, 32'h7F800000, 32'h00000001
    };

    initial begin : driver
        logic [31:0] v;
        int t;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset_n = 1'b1;

        foreach (directed[i]) begin
            if (directed[i] == 32'h40200000) stall_req = 1'b1;
            send(directed[i]);
        end

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom();
                1, 2:    v = {1'b0, 8'($urandom_range(120, 150)), 23'($urandom())};
                default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                              23'(($urandom_range(0, 3) == 0) ? 0 : $urandom())};
            endcase
            send(v);
        end

        // Abort a conversion mid-shift; its result must never appear.
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 2000) begin @(negedge clk); t++; end
        send(32'h3F800000);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset_state("mid_reset");
        reset_n = 1'b1;
        send(32'h46000000);

        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 2000) begin @(negedge clk); t++; end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results never presented", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
